// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: performs loads/stores between execute and
// write-back, presenting a one-cycle registered result slot per instruction.
package mau_pkg;
  localparam int DATA_SIZE  = 32;
  localparam int GPR_SIZE   = 5;
  localparam int OP_WB_SIZE = 2;

  localparam logic [OP_WB_SIZE-1:0] WB_NONE     = 2'b00;
  localparam logic [OP_WB_SIZE-1:0] WB_REGISTER = 2'b01;
  localparam logic [OP_WB_SIZE-1:0] WB_MEMORY   = 2'b10;
endpackage

module memory_access_unit
  import mau_pkg::*;
#(
  parameter int ADDRESS_SIZE = 16,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_SIZE-1:0]    in_result,
  input  logic [GPR_SIZE-1:0]     in_destination,
  input  logic [OP_WB_SIZE-1:0]   in_writeback,
  input  logic                    in_store,
  input  logic [DATA_SIZE-1:0]    in_store_data,

  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [DATA_SIZE-1:0]    mem_write_data,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  input  logic                    mem_ready,
  input  logic [DATA_SIZE-1:0]    mem_read_data,

  output logic [DATA_SIZE-1:0]    result,
  output logic [GPR_SIZE-1:0]     destination,
  output logic [OP_WB_SIZE-1:0]   writeback,
  output logic [DATA_SIZE-1:0]    data_in,
  output logic                    mem_error
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  state_t                state;
  logic [7:0]            count;
  logic [DATA_SIZE-1:0]  lat_result;
  logic [GPR_SIZE-1:0]   lat_destination;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      lat_result       <= '0;
      lat_destination  <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      result           <= '0;
      destination      <= '0;
      writeback        <= WB_NONE;
      data_in          <= '0;
      mem_error        <= 1'b0;
    end else begin
      // Bubble unless a slot is loaded below
      result      <= '0;
      destination <= '0;
      writeback   <= WB_NONE;
      data_in     <= '0;
      mem_error   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_store) begin
              mem_address      <= in_result[ADDRESS_SIZE-1:0];
              mem_write_data   <= in_store_data;
              mem_write_enable <= 1'b1;
              count            <= '0;
              state            <= WRITE_WAIT;
            end else if (in_writeback == WB_MEMORY) begin
              mem_address      <= in_result[ADDRESS_SIZE-1:0];
              lat_result       <= in_result;
              lat_destination  <= in_destination;
              mem_read_enable  <= 1'b1;
              count            <= '0;
              state            <= READ_WAIT;
            end else if (in_writeback == WB_REGISTER) begin
              result      <= in_result;
              destination <= in_destination;
              writeback   <= WB_REGISTER;
            end
          end
        end

        READ_WAIT: begin
          if (mem_ready) begin
            result          <= lat_result;
            destination     <= lat_destination;
            writeback       <= WB_MEMORY;
            data_in         <= mem_read_data;
            mem_read_enable <= 1'b0;
            count           <= '0;
            state           <= IDLE;
          end else if (count == LIMIT) begin
            mem_read_enable <= 1'b0;
            mem_error       <= 1'b1;
            count           <= '0;
            state           <= IDLE;
          end else begin
            count <= count + 8'd1;
          end
        end

        WRITE_WAIT: begin
          if (mem_ready) begin
            mem_write_enable <= 1'b0;
            count            <= '0;
            state            <= IDLE;
          end else if (count == LIMIT) begin
            mem_write_enable <= 1'b0;
            mem_error        <= 1'b1;
            count            <= '0;
            state            <= IDLE;
          end else begin
            count <= count + 8'd1;
          end
        end

        default: begin
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
          count            <= '0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Pipeline stage between execute and write-back.
- Takes one executed instruction per handshake: ALU result, destination register, write-back code, optional store data.
- Performs any data-memory load or store over a ready-based request interface.
- Presents a registered result/destination/writeback/data bundle to the write-back stage.
- Outside a one-cycle valid output slot, the bundle is a WB_NONE bubble, so write-back never writes spuriously.

Parameters:
ADDRESS_SIZE, 16, data-memory address width; taken from result[ADDRESS_SIZE-1:0].
TIMEOUT, 15, maximum memory wait cycles before a transaction is aborted (1..255).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  execute stage presents an instruction
in_ready  output  1  unit can accept; asserted iff state IDLE
in_result  input  `DATA_SIZE  ALU result / effective address
in_destination  input  `GPR_SIZE  destination register
in_writeback  input  `OP_WB_SIZE  WB_REGISTER / WB_MEMORY / WB_NONE
in_store  input  1  instruction is a store
in_store_data  input  `DATA_SIZE  data to store
mem_address  output  ADDRESS_SIZE  memory address, registered
mem_write_data  output  `DATA_SIZE  store data, registered
mem_read_enable  output  1  load request, held until mem_ready
mem_write_enable  output  1  store request, held until mem_ready
mem_ready  input  1  memory completes current request this cycle
mem_read_data  input  `DATA_SIZE  load data, valid when mem_ready=1
result  output  `DATA_SIZE  registered to write-back
destination  output  `GPR_SIZE  registered to write-back
writeback  output  `OP_WB_SIZE  registered to write-back
data_in  output  `DATA_SIZE  registered load data to write-back
mem_error  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset:
  - state IDLE; result, destination, data_in = 0; writeback = WB_NONE.
  - mem_address, mem_write_data = 0; mem_read_enable = mem_write_enable = 0; mem_error = 0; wait counter = 0.
  - A reset during READ_WAIT/WRITE_WAIT drops the transaction; no output slot is produced.
- States: IDLE, READ_WAIT, WRITE_WAIT. in_ready = (state == IDLE), combinational from state only.
- Output bundle default every cycle: writeback = WB_NONE, result/destination/data_in = 0, mem_error = 0, unless loaded as below. Each valid slot lasts exactly one cycle.
- IDLE, accept when in_valid=1:
  - in_store=1 (precedence over in_writeback): latch address/data, mem_write_enable=1, go WRITE_WAIT.
  - in_writeback=WB_MEMORY: latch address, result and destination; mem_read_enable=1; go READ_WAIT.
  - in_writeback=WB_REGISTER: next cycle bundle = {in_result, in_destination, WB_REGISTER, data_in=0}; stay IDLE; 1-cycle latency, full throughput.
  - WB_NONE or any other code: bundle stays bubble; stay IDLE.
- READ_WAIT:
  - mem_ready=1 at an edge: bundle = {latched result, latched destination, WB_MEMORY, mem_read_data}; drop mem_read_enable; counter cleared; go IDLE.
  - Minimum load latency: 2 cycles from acceptance to output slot.
- WRITE_WAIT:
  - mem_ready=1: drop mem_write_enable, go IDLE; bundle stays bubble (WB_NONE).
- Timeout: counter increments each wait cycle with mem_ready=0.
  - When counter == TIMEOUT and mem_ready=0: drop the request, pulse mem_error, bubble output, go IDLE.
  - If mem_ready=1 on that same cycle, completion wins and there is no error.
- mem_address/mem_write_data are stable while a request enable is high. Only one request outstanding; read and write enables are never both high.
- in_valid while in_ready=0 is ignored; upstream holds its bundle.

Test Plan:
- WB_REGISTER back-to-back: in_result 0x11,0x22 on consecutive cycles, dest 3,4 -> writeback=WB_REGISTER with result 0x11/dest 3, then 0x22/dest 4 on the next two cycles; in_ready stays 1.
- Load, ready after 3 cycles: in_result 0x0040, WB_MEMORY, dest 5; mem_read_data 0xDEADBEEF -> mem_read_enable high 3 cycles with mem_address 0x0040; one slot {WB_MEMORY, dest 5, data_in 0xDEADBEEF}; in_ready low during wait.
- Store: in_store=1, addr 0x0010, data 0xCAFE, mem_ready after 1 cycle -> mem_write_enable high 1 cycle with correct address/data; writeback remains WB_NONE throughout.
- Timeout: load with mem_ready held 0, TIMEOUT=15 -> mem_error pulses once; writeback remains WB_NONE; in_ready returns 1. Repeat with mem_ready=1 on the timeout cycle -> normal WB_MEMORY slot, no error.
- Reset mid-load: assert reset in READ_WAIT -> next cycle all outputs at reset values, enables 0, no output slot afterwards even if mem_ready rises.
- Bubble/illegal code: in_valid with WB_NONE and with the unused code -> no write-back slot; write_enable path never sees WB_REGISTER/WB_MEMORY.
